// File: rtl/dct_1d_seq.sv
// dct_1d_seq: sequential N-point DCT-II row engine with one butterfly stage and a single MAC.
// Build option: define DCT_ROUND_EN to round output coefficients (half toward +inf) instead of flooring.
module dct_1d_seq #(
    parameter int N     = 16,
    parameter int IN_W  = 8,
    parameter int OUT_W = 11
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [N*IN_W-1:0]    x_n_in,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [N*OUT_W-1:0]   X_k_out,
    output logic                 busy
);
    localparam int H  = N / 2;
    localparam int KW = $clog2(N);
    localparam int NW = $clog2(H);
    localparam int SW = IN_W + 2;
    localparam int AW = SW + 7 + NW;
`ifdef DCT_ROUND_EN
    localparam int BIAS = 32;
`else
    localparam int BIAS = 0;
`endif
    localparam logic signed [6:0] T16 [16] = '{7'sd16, 7'sd23, 7'sd22, 7'sd22, 7'sd21, 7'sd20, 7'sd19, 7'sd17,
                                               7'sd16, 7'sd14, 7'sd13, 7'sd11, 7'sd9, 7'sd7, 7'sd4, 7'sd2};
    localparam logic signed [6:0] T8 [8] = '{7'sd23, 7'sd31, 7'sd30, 7'sd27, 7'sd23, 7'sd18, 7'sd12, 7'sd6};

    if (!(N == 8 || N == 16)) begin : g_bad_n
        $error("dct_1d_seq: N must be 8 or 16");
    end

    typedef enum logic [1:0] {IDLE, BFLY, MAC, DONE} state_t;

    state_t                  state;
    logic [IN_W-1:0]         x [N];
    logic signed [SW-1:0]    s [H];
    logic signed [SW-1:0]    d [H];
    logic signed [OUT_W-1:0] y [N];
    logic signed [AW-1:0]    acc, acc_nx;
    logic signed [SW+6:0]    prod;
    logic signed [6:0]       coef;
    logic [KW-1:0]           k;
    logic [NW-1:0]           n;

    // Entry 0 of each table is the DC coefficient, entries 1..N-1 are T[m].
    function automatic logic signed [6:0] tab(input int m);
        return (N == 16) ? T16[m[3:0]] : T8[m[2:0]];
    endfunction

    // Folds the cosine phase (2n+1)k into the first quadrant and applies its sign.
    function automatic logic signed [6:0] cval(input logic [KW-1:0] kk, input logic [NW-1:0] nn);
        int m;
        m = ((2 * int'(nn) + 1) * int'(kk)) % (4 * N);
        if (kk == '0) return tab(0);
        if (m < N) return tab(m);
        if (m > N && m < 2 * N) return -tab(2 * N - m);
        if (m > 2 * N && m < 3 * N) return -tab(m - 2 * N);
        if (m > 3 * N) return tab(4 * N - m);
        return 7'sd0;
    endfunction

    assign coef   = cval(k, n);
    assign prod   = (k[0] ? d[n] : s[n]) * coef;
    assign acc_nx = (n == '0 ? AW'(0) : acc) + {{NW{prod[SW+6]}}, prod};

    always_comb begin
        X_k_out = '0;
        for (int i = 0; i < N; i++) X_k_out[(N-1-i)*OUT_W +: OUT_W] = y[i];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            in_ready  <= 1'b0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            acc       <= '0;
            k         <= '0;
            n         <= '0;
            for (int i = 0; i < N; i++) y[i] <= '0;
        end else begin
            case (state)
                IDLE: begin
                    in_ready <= 1'b1;
                    if (in_valid && in_ready) begin
                        for (int i = 0; i < N; i++) x[i] <= x_n_in[(N-1-i)*IN_W +: IN_W];
                        in_ready <= 1'b0;
                        busy     <= 1'b1;
                        state    <= BFLY;
                    end
                end
                BFLY: begin
                    for (int i = 0; i < H; i++) begin
                        s[i] <= $signed({2'b0, x[i]}) + $signed({2'b0, x[N-1-i]});
                        d[i] <= $signed({2'b0, x[i]}) - $signed({2'b0, x[N-1-i]});
                    end
                    k     <= '0;
                    n     <= '0;
                    state <= MAC;
                end
                MAC: begin
                    acc <= acc_nx;
                    n   <= n + 1'b1;
                    if (n == NW'(H - 1)) begin
                        y[k] <= OUT_W'((acc_nx + AW'(BIAS)) >>> 6);
                        k    <= k + 1'b1;
                        if (k == KW'(N - 1)) begin
                            busy      <= 1'b0;
                            out_valid <= 1'b1;
                            state     <= DONE;
                        end
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
